// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the RX stream: classifies each frame on its
// first beat and forwards it through a one-deep output slice or drops it.
module eth_rx_mac_filter #(
    parameter int ACCEPT_BCAST = 1,
    parameter int ACCEPT_MCAST = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          mac_addr,
    input  logic                 promisc,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [511:0]         s_tdata,
    input  logic [63:0]          s_tkeep,
    input  logic                 s_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [511:0]         m_tdata,
    output logic [63:0]          m_tkeep,
    output logic                 m_tlast,
    output logic [CNT_WIDTH-1:0] dbg_accepted,
    output logic [CNT_WIDTH-1:0] dbg_filtered,
    output logic [CNT_WIDTH-1:0] dbg_runt
);

    typedef enum logic [1:0] {
        HEAD,
        FWD,
        DROP
    } state_t;

    localparam logic ACC_B = (ACCEPT_BCAST != 0);
    localparam logic ACC_M = (ACCEPT_MCAST != 0);

    state_t state;
    state_t state_next;

    logic [47:0] da;
    logic        ucast_hit;
    logic        bcast;
    logic        mcast;
    logic        runt;
    logic        pass;
    logic        slice_ready;
    logic        xfer;
    logic        load;
    logic        first;

    // Byte 0 on the wire is the most significant byte of the address.
    assign da = {s_tdata[7:0],   s_tdata[15:8],  s_tdata[23:16],
                 s_tdata[31:24], s_tdata[39:32], s_tdata[47:40]};

    assign ucast_hit = (da == mac_addr);
    assign bcast     = (da == 48'hFFFF_FFFF_FFFF);
    assign mcast     = s_tdata[0] & ~bcast;
    assign runt      = s_tlast & (s_tkeep[5:0] != 6'h3F);

    assign pass = ~runt & (promisc | ucast_hit |
                           (bcast & ACC_B) | (mcast & ACC_M));

    assign slice_ready = ~m_tvalid | m_tready;
    assign xfer        = s_tvalid & s_tready;

    always_comb begin
        state_next = state;
        s_tready   = slice_ready;
        load       = 1'b0;
        first      = 1'b0;
        unique case (state)
            HEAD: begin
                if (s_tvalid & slice_ready) begin
                    first = 1'b1;
                    load  = pass;
                    if (!s_tlast) begin
                        state_next = pass ? FWD : DROP;
                    end
                end
            end
            FWD: begin
                if (s_tvalid & slice_ready) begin
                    load = 1'b1;
                    if (s_tlast) begin
                        state_next = HEAD;
                    end
                end
            end
            DROP: begin
                // Discarded beats never touch the slice, so never stall.
                s_tready = 1'b1;
                if (s_tvalid & s_tlast) begin
                    state_next = HEAD;
                end
            end
            default: begin
                state_next = HEAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HEAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // One increment per frame, decided on the first-beat transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_accepted <= '0;
            dbg_filtered <= '0;
            dbg_runt     <= '0;
        end else if (first && xfer) begin
            if (runt) begin
                dbg_runt <= sat_inc(dbg_runt);
            end else if (pass) begin
                dbg_accepted <= sat_inc(dbg_accepted);
            end else begin
                dbg_filtered <= sat_inc(dbg_filtered);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Bench for eth_rx_mac_filter: directed frames plus randomized traffic
// checked every cycle against a frame-level model.
module tb_eth_rx_mac_filter;

    localparam int CW    = 4;
    localparam int ACC_B = 1;
    localparam int ACC_M = 0;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    logic          clk = 1'b0;
    logic          rst;
    logic [47:0]   mac_addr;
    logic          promisc;
    logic          s_tvalid;
    logic          s_tready;
    logic [511:0]  s_tdata;
    logic [63:0]   s_tkeep;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [511:0]  m_tdata;
    logic [63:0]   m_tkeep;
    logic          m_tlast;
    logic [CW-1:0] dbg_accepted;
    logic [CW-1:0] dbg_filtered;
    logic [CW-1:0] dbg_runt;

    eth_rx_mac_filter #(
        .ACCEPT_BCAST(ACC_B),
        .ACCEPT_MCAST(ACC_M),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mac_addr    (mac_addr),
        .promisc     (promisc),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .dbg_accepted(dbg_accepted),
        .dbg_filtered(dbg_filtered),
        .dbg_runt    (dbg_runt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        int           c;
    } beat_t;

    beat_t expq[$];
    beat_t fr[$];
    beat_t e;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int exp_acc, exp_flt, exp_runt;
    bit dropping, lat_chk, mon_en, gaps, mut;
    int rdy_mode;
    int pi = 0;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Frame-level classification straight from the address rules.
    function automatic void classify(input beat_t b, output bit pass,
                                     output bit runt);
        logic [47:0] da;
        bit bc, mc, uc;
        for (int j = 0; j < 6; j++) da[47-8*j -: 8] = b.d[8*j +: 8];
        runt = b.l && (b.k[5:0] != 6'h3F);
        bc   = (da == BCAST);
        mc   = da[40] && !bc;
        uc   = (da == mac_addr);
        pass = !runt && (promisc || uc || (bc && ACC_B != 0) ||
                         (mc && ACC_M != 0));
    endfunction

    task automatic build(input logic [47:0] da, input int nb,
                         input int last_bytes);
        beat_t b;
        fr = {};
        for (int i = 0; i < nb; i++) begin
            for (int w = 0; w < 16; w++) b.d[32*w +: 32] = $urandom;
            b.l = (i == nb - 1);
            b.k = '1;
            if (i == 0)
                for (int j = 0; j < 6; j++) b.d[8*j +: 8] = da[47-8*j -: 8];
            if (b.l && last_bytes < 64) b.k = (64'd1 << last_bytes) - 64'd1;
            b.c = 0;
            fr.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        bit pass, runt, fwd;
        int wn, g;
        beat_t b;
        fwd = 0;
        for (int i = 0; i < fr.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = fr[i].d;
            s_tkeep  = fr[i].k;
            s_tlast  = fr[i].l;
            wn = 0;
            @(negedge clk);
            while (!s_tready && wn < 200) begin
                @(negedge clk);
                wn++;
            end
            if (!s_tready) begin
                n_tot++;
                $display("FAIL handshake_timeout: s_tready 0 for %0d cycles, required 1",
                         wn);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i == 0) begin
                classify(fr[0], pass, runt);
                if (runt) exp_runt = sat(exp_runt);
                else if (pass) exp_acc = sat(exp_acc);
                else exp_flt = sat(exp_flt);
                fwd = pass;
                dropping = !pass && !fr[0].l;
                if (mut && $urandom_range(0, 1) == 1) begin
                    mac_addr = (mac_addr == MAC_A) ? MAC_B : MAC_A;
                    promisc  = ~promisc;
                end
            end
            if (fwd) begin
                b   = fr[i];
                b.c = cyc;
                expq.push_back(b);
            end
            if (fr[i].l) dropping = 0;
            if (gaps) begin
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    s_tvalid = 1'b0;
                    idle(g);
                end
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    task automatic clear_model();
        expq.delete();
        exp_acc  = 0;
        exp_flt  = 0;
        exp_runt = 0;
        dropping = 0;
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = pat[pi % 4];
            endcase
            pi++;
        end
    end

    logic [511:0] pd;
    logic [63:0]  pk;
    logic         pl;
    bit           pstall;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pstall = 0;
        end else if (mon_en) begin
            chk("s_tready", s_tready,
                dropping ? 1'b1 : (!m_tvalid || m_tready));
            chk("dbg_accepted", dbg_accepted, exp_acc);
            chk("dbg_filtered", dbg_filtered, exp_flt);
            chk("dbg_runt", dbg_runt, exp_runt);
            if (pstall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, pd);
                chk("stall_keep", m_tkeep, pk);
                chk("stall_last", m_tlast, pl);
            end
            if (m_tvalid && m_tready) begin
                chk("beat_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("m_tdata", m_tdata, e.d);
                    chk("m_tkeep", m_tkeep, e.k);
                    chk("m_tlast", m_tlast, e.l);
                    if (lat_chk) chk("latency", cyc - e.c, 1);
                end
            end
            pstall = m_tvalid && !m_tready;
            pd = m_tdata;
            pk = m_tkeep;
            pl = m_tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] da;
        int nb, lb;
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        mac_addr = MAC_A;
        promisc = 1'b0;
        rdy_mode = 0;
        mon_en = 0;
        lat_chk = 1;
        gaps = 0;
        mut = 0;
        clear_model();
        idle(3);
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_m_tdata", m_tdata, 0);
        chk("reset_m_tkeep", m_tkeep, 0);
        chk("reset_m_tlast", m_tlast, 0);
        chk("reset_accepted", dbg_accepted, 0);
        chk("reset_filtered", dbg_filtered, 0);
        chk("reset_runt", dbg_runt, 0);
        rst = 1'b0;
        mon_en = 1;
        idle(2);

        build(MAC_A, 3, 64);
        send_frame();
        idle(4);
        chk("t1_accepted", dbg_accepted, 1);
        chk("t1_drained", expq.size(), 0);

        build(MAC_B, 2, 64);
        send_frame();
        idle(3);
        chk("t2_filtered", dbg_filtered, 1);
        promisc = 1'b1;
        send_frame();
        idle(3);
        chk("t2_promisc_accepted", dbg_accepted, 2);
        promisc = 1'b0;

        build(BCAST, 2, 64);
        send_frame();
        build(MCAST, 1, 64);
        send_frame();
        idle(3);
        chk("t3_accepted", dbg_accepted, 3);
        chk("t3_filtered", dbg_filtered, 2);

        build(MAC_A, 1, 5);
        send_frame();
        idle(2);
        chk("t4_runt", dbg_runt, 1);
        build(MAC_A, 1, 6);
        chk("t4_keep_model", fr[0].k, 64'h3F);
        send_frame();
        idle(3);
        chk("t4_accepted", dbg_accepted, 4);

        rdy_mode = 2;
        lat_chk = 0;
        build(MAC_A, 4, 64);
        send_frame();
        build(MAC_A, 4, 40);
        send_frame();
        drain();
        chk("t5_accepted", dbg_accepted, 6);
        rdy_mode = 0;
        idle(3);
        lat_chk = 1;

        build(MAC_A, 4, 64);
        s_tvalid = 1'b1;
        s_tdata = fr[0].d;
        s_tkeep = fr[0].k;
        s_tlast = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_tdata = fr[1].d;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_m_tvalid", m_tvalid, 0);
        chk("rst_mid_accepted", dbg_accepted, 0);
        chk("rst_mid_filtered", dbg_filtered, 0);
        chk("rst_mid_runt", dbg_runt, 0);
        s_tvalid = 1'b0;
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        build(MAC_A, 3, 64);
        send_frame();
        idle(4);
        chk("t6_accepted", dbg_accepted, 1);
        chk("t6_drained", expq.size(), 0);

        gaps = 1;
        mut = 1;
        for (int blk = 0; blk < 9; blk++) begin
            if (blk == 4) begin
                drain();
                rst = 1'b1;
                clear_model();
                idle(1);
                rst = 1'b0;
            end
            lat_chk = 0;
            rdy_mode = blk % 3;
            drain();
            idle(2);
            lat_chk = (rdy_mode == 0);
            for (int f = 0; f < 20; f++) begin
                case ($urandom_range(0, 4))
                    0: da = MAC_A;
                    1: da = MAC_B;
                    2: da = BCAST;
                    3: da = {16'($urandom), $urandom} | 48'h01_00_00_00_00_00;
                    default: da = {16'($urandom), $urandom} & ~48'h01_00_00_00_00_00;
                endcase
                nb = $urandom_range(1, 4);
                lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7)
                                                 : $urandom_range(1, 64);
                if ($urandom_range(0, 3) == 0) begin
                    mac_addr = ($urandom_range(0, 1) == 1) ? MAC_A : MAC_B;
                    promisc = ($urandom_range(0, 4) == 0);
                end
                build(da, nb, lb);
                send_frame();
            end
        end
        lat_chk = 0;
        rdy_mode = 0;
        drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/eth_rx_mac_filter.md
Name: eth_rx_mac_filter

Overview:
Destination-MAC filter directly downstream of the RX frame FIFO, consuming its 512-bit AXI-Stream output (so_*). It classifies each frame on its first beat as unicast-match, broadcast, multicast, or other, and forwards or silently drops the whole frame. Frames whose first beat carries fewer than 6 bytes are dropped as runts. Output is a 1-deep registered AXI-Stream slice; drop/accept statistics are exported for the AXI-Lite debug block.

Parameters:
ACCEPT_BCAST, 1, forward broadcast (FF:FF:FF:FF:FF:FF) frames when 1
ACCEPT_MCAST, 1, forward multicast (DA byte0 bit0 = 1, not broadcast) frames when 1
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
mac_addr  in  48  local MAC; mac_addr[47:40] is the first byte on the wire
promisc  in  1  forward all non-runt frames when 1
s_tvalid  in  1  input beat valid
s_tready  out  1  input beat accepted
s_tdata  in  512  input data; byte n = s_tdata[8n+7:8n]; byte 0 is first on the wire
s_tkeep  in  64  byte enables, contiguous from bit 0
s_tlast  in  1  last beat of frame
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream ready
m_tdata  out  512  output data
m_tkeep  out  64  output byte enables
m_tlast  out  1  output last beat
dbg_accepted  out  CNT_WIDTH  frames forwarded
dbg_filtered  out  CNT_WIDTH  frames dropped by the address filter
dbg_runt  out  CNT_WIDTH  frames dropped as runts

Behaviour:
- Reset (async assert, synchronous release): state=HEAD; m_tvalid=0; m_tdata/m_tkeep/m_tlast=0; all counters=0.
- Input beat transfer = s_tvalid & s_tready. Output transfer = m_tvalid & m_tready.
- DA = {byte0..byte5} of the first beat; ucast_hit = (DA == mac_addr); bcast = (DA == 48'hFFFF_FFFF_FFFF); mcast = byte0[0] & !bcast.
- runt = first beat with s_tlast=1 and s_tkeep[5:0] != 6'h3F.
- pass = !runt & (promisc | ucast_hit | (bcast & ACCEPT_BCAST) | (mcast & ACCEPT_MCAST)).
- mac_addr and promisc are sampled only on the first-beat transfer; changes mid-frame do not affect that frame.
- States:
  HEAD: waits for first beat. s_tready = !m_tvalid | m_tready. On transfer: if pass, load output slice; go to HEAD if s_tlast, else FWD. If !pass, slice not loaded; go to HEAD if s_tlast, else DROP.
  FWD: s_tready = !m_tvalid | m_tready; each transfer loads the slice; on s_tlast return to HEAD.
  DROP: s_tready = 1; beats discarded; on s_tlast return to HEAD.
- Output slice: m_tvalid set on load, cleared on output transfer without a same-cycle load. Load and unload in the same cycle keep m_tvalid=1 with new data. Latency input->output = 1 cycle; full throughput (1 beat/cycle) with m_tready held high.
- m_tvalid never drops while m_tready=0 (AXIS stability); m_tdata/m_tkeep/m_tlast hold stable until the transfer.
- Counters increment once per frame, on the first-beat transfer: dbg_accepted if pass, dbg_runt if runt, dbg_filtered otherwise. Counters saturate at all-ones and do not wrap.
- Single-beat frames (first beat has s_tlast=1) are classified and completed in HEAD.
- Reset mid-frame: state returns to HEAD and any beat in the slice is lost. The next input beat is treated as a first beat; the upstream FIFO emits whole frames only after its own reset.

Test Plan:
- mac_addr=02:00:00:00:00:01, promisc=0; 3-beat frame with DA=02:00:00:00:00:01 and m_tready=1 -> 3 beats out, each 1 cycle after input, last with m_tlast=1; dbg_accepted=1.
- 2-beat frame with DA=02:00:00:00:00:02 -> no m_tvalid; s_tready=1 on both beats; dbg_filtered=1. Then promisc=1, same frame -> forwarded; dbg_accepted=1.
- ACCEPT_BCAST=1, ACCEPT_MCAST=0: broadcast frame -> forwarded; frame with DA=01:00:5E:00:00:01 -> dropped; dbg_accepted=1, dbg_filtered=1.
- Single beat with s_tlast=1 and s_tkeep=64'h1F -> dropped, dbg_runt=1. Single beat with s_tkeep=64'h3F and matching DA -> forwarded with m_tkeep=64'h3F.
- Back-to-back 4-beat matching frames with m_tready toggling 1,0,0,1 -> no beat lost or duplicated; data stable while stalled; s_tready=0 whenever m_tvalid=1 and m_tready=0.
- Assert rst during beat 2 of a 4-beat forwarded frame -> m_tvalid=0 and counters=0 immediately; following fresh frame classified and forwarded normally.
